pe_array_feeder: RTL and testbench

//  Drives the west (hrzt) and north (vrtc) edges of an N x N systolic array of PEs, plus the array-wide pass control.

---
 rtl/pe_array_pkg.sv | 20 ++
 rtl/skew_line.sv | 36 +++
 rtl/pe_array_feeder.sv | 113 +++++++++++
 tb/tb_pe_array_feeder.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_array_pkg.sv
// rtl/pe_array_pkg.sv - shared defaults, FSM state codes and counter sizing for the PE array feeder
package pe_array_pkg;

    localparam int DEF_N  = 4;
    localparam int DEF_DW = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FEED  = 3'd1,
        ST_FLUSH = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Phase counter must span the longer of the flush (2N-1) and drain phases.
    function automatic int cnt_width(input int n, input int drain);
        return $clog2(2 * n + drain);
    endfunction

endpackage

// File: rtl/skew_line.sv
// rtl/skew_line.sv - DEPTH-stage register delay line for one operand lane
// Ports:
//   clk   in   rising-edge clock
//   rst_n in   asynchronous active-low reset, clears every stage
//   din   in   DW-bit lane input
//   dout  out  din delayed by DEPTH cycles (DEPTH=0: straight wire)
module skew_line #(
    parameter int DW    = 16,
    parameter int DEPTH = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign dout = din;
        end else begin : g_regs
            logic [DW-1:0] stage [DEPTH];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int j = 0; j < DEPTH; j++) stage[j] <= '0;
                end else begin
                    stage[0] <= din;
                    for (int j = 1; j < DEPTH; j++) stage[j] <= stage[j-1];
                end
            end

            assign dout = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/pe_array_feeder.sv
// rtl/pe_array_feeder.sv - skews k-slices onto the west/north edges of an N x N systolic array and sequences flush/drain
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready slice beat handshake; in_last marks the final k-slice of a tile
//   a_col, b_row      A[:,k] and B[k,:], lane i in bits [i*DW +: DW]
//   hrzt_o, vrtc_o    skewed lanes to PE(r,0) and PE(0,c); lane i delayed i cycles
//   pass_o            1 = shift/drain, 0 = compute
//   busy, done        busy outside IDLE; done pulses one cycle after drain
module pe_array_feeder
    import pe_array_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int DW    = DEF_DW,
    parameter int DRAIN = N
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_last,
    input  logic [N*DW-1:0] a_col,
    input  logic [N*DW-1:0] b_row,
    output logic [N*DW-1:0] hrzt_o,
    output logic [N*DW-1:0] vrtc_o,
    output logic            pass_o,
    output logic            busy,
    output logic            done
);

    localparam int             CW        = cnt_width(N, DRAIN);
    localparam logic [CW-1:0]  FLUSH_END = CW'(2 * N - 2);
    localparam logic [CW-1:0]  DRAIN_END = CW'(DRAIN - 1);

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic            ready_q;
    logic            xfer;
    logic [N*DW-1:0] inj_a;
    logic [N*DW-1:0] inj_b;

    assign xfer = in_valid & ready_q;

    // State register, phase counter and registered ready. Ready is computed
    // from the next state so it is 0 during reset and rises on the first edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            ready_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            ready_q <= (state_nxt == ST_IDLE) || (state_nxt == ST_FEED);
            if (state_nxt != state)
                cnt <= '0;
            else if (state == ST_FLUSH || state == ST_DRAIN)
                cnt <= cnt + CW'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (xfer) state_nxt = in_last ? ST_FLUSH : ST_FEED;
            ST_FEED:  if (xfer && in_last) state_nxt = ST_FLUSH;
            ST_FLUSH: if (cnt == FLUSH_END) state_nxt = ST_DRAIN;
            ST_DRAIN: if (cnt == DRAIN_END) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = ready_q;
        pass_o   = (state == ST_IDLE) || (state == ST_DRAIN) || (state == ST_DONE);
        busy     = (state != ST_IDLE);
        done     = (state == ST_DONE);
    end

    // Injection register: the accepted beat, or an all-zero bubble which is
    // MAC-neutral and keeps the skew lines advancing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inj_a <= '0;
            inj_b <= '0;
        end else if (xfer) begin
            inj_a <= a_col;
            inj_b <= b_row;
        end else begin
            inj_a <= '0;
            inj_b <= '0;
        end
    end

    assign hrzt_o[DW-1:0] = inj_a[DW-1:0];
    assign vrtc_o[DW-1:0] = inj_b[DW-1:0];

    for (genvar i = 1; i < N; i++) begin : g_lane
        skew_line #(.DW(DW), .DEPTH(i)) u_skew_a (
            .clk   (clk),
            .rst_n (rst_n),
            .din   (inj_a[i*DW +: DW]),
            .dout  (hrzt_o[i*DW +: DW])
        );
        skew_line #(.DW(DW), .DEPTH(i)) u_skew_b (
            .clk   (clk),
            .rst_n (rst_n),
            .din   (inj_b[i*DW +: DW]),
            .dout  (vrtc_o[i*DW +: DW])
        );
    end

endmodule

// File: tb/tb_pe_array_feeder.sv
// tb/tb_pe_array_feeder.sv - directed self-checking bench for pe_array_feeder (N=4, DW=16)
module tb_pe_array_feeder;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int W  = N * DW;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic         in_last;
    logic [W-1:0] a_col;
    logic [W-1:0] b_row;
    logic [W-1:0] hrzt_o;
    logic [W-1:0] vrtc_o;
    logic         pass_o;
    logic         busy;
    logic         done;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] ha [N];
    logic [W-1:0] hb [N];

    typedef struct {
        logic         v;
        logic         l;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] eh;
        logic [W-1:0] ev;
        logic         pass;
        logic         rdy;
        logic         bsy;
        logic         dn;
    } vec_t;

    vec_t tbl [13];

    pe_array_feeder #(.N(N), .DW(DW), .DRAIN(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_last  (in_last),
        .a_col    (a_col),
        .b_row    (b_row),
        .hrzt_o   (hrzt_o),
        .vrtc_o   (vrtc_o),
        .pass_o   (pass_o),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] pk(input int x3, input int x2, input int x1, input int x0);
        return {x3[15:0], x2[15:0], x1[15:0], x0[15:0]};
    endfunction

    task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_hist();
        for (int i = 0; i < N; i++) begin
            ha[i] = '0;
            hb[i] = '0;
        end
    endtask

    // One clock: check ready, drive a beat, then compare every lane with the
    // beat injected i edges earlier.
    task automatic cyc(input logic v, input logic l, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic er);
        logic [W-1:0] exp_h;
        logic [W-1:0] exp_v;
        chk1("in_ready_pre", in_ready, er);
        in_valid = v;
        in_last  = l;
        a_col    = a;
        b_row    = b;
        for (int i = N - 1; i > 0; i--) begin
            ha[i] = ha[i-1];
            hb[i] = hb[i-1];
        end
        ha[0] = (v && er) ? a : '0;
        hb[0] = (v && er) ? b : '0;
        @(posedge clk);
        @(negedge clk);
        exp_h = '0;
        exp_v = '0;
        for (int i = 0; i < N; i++) begin
            exp_h[i*DW +: DW] = ha[i][i*DW +: DW];
            exp_v[i*DW +: DW] = hb[i][i*DW +: DW];
        end
        chkw("hrzt", hrzt_o, exp_h);
        chkw("vrtc", vrtc_o, exp_v);
    endtask

    // After the in_last transfer: 7 flush, 4 drain, 1 done, then idle.
    // in_valid is held high with junk to show nothing is accepted.
    task automatic tail();
        for (int j = 1; j <= 12; j++) begin
            cyc(1'b1, j[0], pk(111, 222, 333, 444), pk(-5, -6, -7, -8), 1'b0);
            chk1("pass", pass_o, j >= 7);
            chk1("done", done, j == 11);
            chk1("busy", busy, j <= 11);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        a_col    = '0;
        b_row    = '0;
        clear_hist();

        // Reset state
        repeat (2) @(negedge clk);
        chkw("rst_hrzt", hrzt_o, '0);
        chkw("rst_vrtc", vrtc_o, '0);
        chk1("rst_pass", pass_o, 1'b1);
        chk1("rst_ready", in_ready, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        rst_n = 1'b1;
        #1;
        chk1("rel_ready_now", in_ready, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk1("rel_ready_next", in_ready, 1'b1);
        chk1("rel_busy", busy, 1'b0);

        // Single-beat tile with in_valid held through flush/drain
        tbl[0] = '{1'b1, 1'b1, pk(4, 3, 2, 1), pk(8, 7, 6, 5), pk(0, 0, 0, 1), pk(0, 0, 0, 5),
                   1'b0, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 1'b0, pk(99, 98, 97, 96), pk(-9, -9, -9, -9), pk(0, 0, 2, 0), pk(0, 0, 6, 0),
                   1'b0, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 1'b1, pk(99, 98, 97, 96), pk(-9, -9, -9, -9), pk(0, 3, 0, 0), pk(0, 7, 0, 0),
                   1'b0, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b0, pk(99, 98, 97, 96), pk(-9, -9, -9, -9), pk(4, 0, 0, 0), pk(8, 0, 0, 0),
                   1'b0, 1'b0, 1'b1, 1'b0};
        for (int k = 4; k <= 6; k++)
            tbl[k] = '{1'b1, k[0], pk(99, 98, 97, 96), pk(-9, -9, -9, -9), '0, '0,
                       1'b0, 1'b0, 1'b1, 1'b0};
        for (int k = 7; k <= 10; k++)
            tbl[k] = '{1'b1, k[0], pk(99, 98, 97, 96), pk(-9, -9, -9, -9), '0, '0,
                       1'b1, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 1'b1, pk(99, 98, 97, 96), pk(-9, -9, -9, -9), '0, '0,
                    1'b1, 1'b0, 1'b1, 1'b1};
        tbl[12] = '{1'b1, 1'b0, pk(99, 98, 97, 96), pk(-9, -9, -9, -9), '0, '0,
                    1'b1, 1'b1, 1'b0, 1'b0};

        for (int k = 0; k < 13; k++) begin
            in_valid = tbl[k].v;
            in_last  = tbl[k].l;
            a_col    = tbl[k].a;
            b_row    = tbl[k].b;
            @(posedge clk);
            @(negedge clk);
            chkw($sformatf("t%0d_hrzt", k), hrzt_o, tbl[k].eh);
            chkw($sformatf("t%0d_vrtc", k), vrtc_o, tbl[k].ev);
            chk1($sformatf("t%0d_pass", k), pass_o, tbl[k].pass);
            chk1($sformatf("t%0d_ready", k), in_ready, tbl[k].rdy);
            chk1($sformatf("t%0d_busy", k), busy, tbl[k].bsy);
            chk1($sformatf("t%0d_done", k), done, tbl[k].dn);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        clear_hist();

        // Four back-to-back beats
        cyc(1'b1, 1'b0, pk(13, 12, 11, 10), pk(23, 22, 21, 20), 1'b1);
        cyc(1'b1, 1'b0, pk(33, 32, 31, 30), pk(43, 42, 41, 40), 1'b1);
        cyc(1'b1, 1'b0, pk(53, 52, 51, 50), pk(63, 62, 61, 60), 1'b1);
        cyc(1'b1, 1'b1, pk(73, 72, 71, 70), pk(83, 82, 81, 80), 1'b1);
        chkw("b2b_lane3_beat0", {48'h0, hrzt_o[3*DW +: DW]}, 64'd13);
        tail();

        // Two-cycle valid gap mid-tile
        cyc(1'b1, 1'b0, pk(4, 3, 2, 1), pk(-4, -3, -2, -1), 1'b1);
        cyc(1'b1, 1'b0, pk(8, 7, 6, 5), pk(-8, -7, -6, -5), 1'b1);
        cyc(1'b0, 1'b1, pk(77, 77, 77, 77), pk(77, 77, 77, 77), 1'b1);
        cyc(1'b0, 1'b0, pk(66, 66, 66, 66), pk(66, 66, 66, 66), 1'b1);
        cyc(1'b1, 1'b0, pk(12, 11, 10, 9), pk(-12, -11, -10, -9), 1'b1);
        cyc(1'b1, 1'b1, pk(16, 15, 14, 13), pk(-16, -15, -14, -13), 1'b1);
        tail();

        // Asynchronous reset mid-FEED
        cyc(1'b1, 1'b0, pk(4, 3, 2, 1), pk(8, 7, 6, 5), 1'b1);
        cyc(1'b1, 1'b0, pk(9, 9, 9, 9), pk(9, 9, 9, 9), 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chkw("arst_hrzt", hrzt_o, '0);
        chkw("arst_vrtc", vrtc_o, '0);
        chk1("arst_pass", pass_o, 1'b1);
        chk1("arst_ready", in_ready, 1'b0);
        chk1("arst_busy", busy, 1'b0);
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        clear_hist();
        @(posedge clk);
        @(negedge clk);
        chk1("arst_ready_after", in_ready, 1'b1);
        chkw("arst_hrzt_after", hrzt_o, '0);

        // Negative operands, single-beat tile straight from IDLE
        cyc(1'b1, 1'b1, pk(-256, -1, -256, -1), pk(-1, -256, -1, -256), 1'b1);
        tail();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
